// File: rtl/seq_sampler_pkg.sv
// Shared types and defaults for the step-sequencer sampler.
package seq_sampler_pkg;

    localparam int DEF_KEYS     = 9;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_TICK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Playback step enable: free-runs a TICK_DIV counter while clear is low and
// pulses tick on the last count of each period.
module seq_tick_gen
    import seq_sampler_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            TW   = clog2_min1(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_q;

    // Period counter, held at zero whenever playback is not active.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                      cnt_q <= '0;
        else if (clear || cnt_q == LAST) cnt_q <= '0;
        else                             cnt_q <= cnt_q + 1'b1;
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/seq_sampler.sv
// Multi-channel key step recorder / player.
// Optional feature: define SEQ_SAMPLER_LOOP_EN to let the loop input wrap
// playback back to step 0; otherwise playback always ends in DONE.
module seq_sampler
    import seq_sampler_pkg::*;
#(
    parameter int KEYS     = DEF_KEYS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [KEYS-1:0]                    key_in,
    input  logic                               key_strobe,
    input  logic [clog2_min1(CHANNELS)-1:0]    chan_sel,
    input  logic                               rec_en,
    input  logic                               play_en,
    input  logic                               loop,
    input  logic                               clear,
    output logic [KEYS-1:0]                    note_out,
    output logic                               recording,
    output logic                               playing,
    output logic [CHANNELS-1:0]                full,
    output logic [clog2_min1(DEPTH)-1:0]       step_idx
);
    localparam int            CW      = clog2_min1(CHANNELS);
    localparam int            DW      = clog2_min1(DEPTH);
    localparam int            LW      = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    state_t                     state_q, state_d;
    logic [CHANNELS-1:0][LW-1:0] len_q;
    logic [KEYS-1:0]            mem [CHANNELS][DEPTH];
    logic [CW-1:0]              ch_q, ch_d;
    logic [DW-1:0]              ptr_q, ptr_d, ptr_nx, wr_idx;
    logic [LW-1:0]              cur_len, last_l;
    logic [KEYS-1:0]            note_d;
    logic                       wr_en, len_zero, sel_ok, tick, loop_on, strobe_ok;

`ifdef SEQ_SAMPLER_LOOP_EN
    assign loop_on = loop;
`else
    logic loop_unused;
    assign loop_unused = loop;
    assign loop_on     = 1'b0;
`endif

    assign sel_ok    = int'(chan_sel) < CHANNELS;
    assign cur_len   = len_q[ch_q];
    assign last_l    = cur_len - 1'b1;
    assign wr_idx    = cur_len[DW-1:0];
    assign ptr_nx    = ptr_q + 1'b1;
    // A step is either a single key or a rest (no keys).
    assign strobe_ok = key_strobe && (key_in == '0 || $onehot(key_in)) && (cur_len < DEPTH_L);

    seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (state_q != ST_PLAY),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, next note and datapath controls.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        ptr_d    = ptr_q;
        note_d   = '0;
        wr_en    = 1'b0;
        len_zero = 1'b0;
        case (state_q)
            ST_IDLE: begin
                note_d = $onehot(key_in) ? key_in : '0;
                if (rec_en && sel_ok) begin
                    state_d  = ST_RECORD;
                    ch_d     = chan_sel;
                    len_zero = 1'b1;
                    note_d   = '0;
                end else if (clear && sel_ok) begin
                    len_zero = 1'b1;
                end else if (play_en && sel_ok && len_q[chan_sel] != '0) begin
                    state_d = ST_PLAY;
                    ch_d    = chan_sel;
                    ptr_d   = '0;
                    note_d  = mem[chan_sel][0];
                end
            end
            ST_RECORD: begin
                if (!rec_en) begin
                    state_d = ST_IDLE;
                end else if (strobe_ok) begin
                    wr_en  = 1'b1;
                    note_d = key_in;
                end
            end
            ST_PLAY: begin
                if (!play_en) begin
                    state_d = ST_IDLE;
                end else if (!tick) begin
                    note_d = note_out;
                end else if (ptr_q != last_l[DW-1:0]) begin
                    ptr_d  = ptr_nx;
                    note_d = mem[ch_q][ptr_nx];
                end else if (loop_on) begin
                    ptr_d  = '0;
                    note_d = mem[ch_q][0];
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!play_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, channel latch, play pointer and channel lengths.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            note_out <= '0;
            ch_q     <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
        end else begin
            note_out <= note_d;
            ch_q     <= ch_d;
            ptr_q    <= ptr_d;
            if (len_zero)   len_q[chan_sel] <= '0;
            else if (wr_en) len_q[ch_q]     <= cur_len + 1'b1;
        end
    end

    // Step storage; contents are only meaningful below each channel's length.
    always_ff @(posedge clock) begin
        if (wr_en) mem[ch_q][wr_idx] <= key_in;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_full
        assign full[c] = (len_q[c] == DEPTH_L);
    end

    assign recording = (state_q == ST_RECORD);
    assign playing   = (state_q == ST_PLAY);
    assign step_idx  = (state_q == ST_RECORD) ? wr_idx :
                       (state_q == ST_PLAY || state_q == ST_DONE) ? ptr_q : '0;

endmodule

// File: tb/tb_seq_sampler.sv
// Directed bench for seq_sampler (KEYS=9, DEPTH=4, CHANNELS=2, TICK_DIV=3).
module tb_seq_sampler;
    localparam int KEYS = 9, DEPTH = 4, CHANNELS = 2, TICK_DIV = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [KEYS-1:0]     key_in = '0;
    logic                key_strobe = 1'b0;
    logic [0:0]          chan_sel = '0;
    logic                rec_en = 1'b0, play_en = 1'b0, loop = 1'b0, clear = 1'b0;
    logic [KEYS-1:0]     note_out;
    logic                recording, playing;
    logic [CHANNELS-1:0] full;
    logic [1:0]          step_idx;

    int total = 0;
    int bad   = 0;
    logic [KEYS-1:0] exp_q [$];
    logic [KEYS-1:0] rec_seq [4] = '{9'h100, 9'h080, 9'h000, 9'h001};
    logic [1:0]      rec_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    seq_sampler #(.KEYS(KEYS), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .TICK_DIV(TICK_DIV)) dut (
        .clock(clock), .reset(reset), .key_in(key_in), .key_strobe(key_strobe),
        .chan_sel(chan_sel), .rec_en(rec_en), .play_en(play_en), .loop(loop), .clear(clear),
        .note_out(note_out), .recording(recording), .playing(playing),
        .full(full), .step_idx(step_idx)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [KEYS-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk_note(input string tag);
        logic [KEYS-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, note_out);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(note_out), 32'(e));
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_note", 32'(note_out), 0);
        chk("rst_rec",  32'(recording), 0);
        chk("rst_play", 32'(playing), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_idx",  32'(step_idx), 0);
        step();
        reset = 1'b1;

        // IDLE passthrough: one-hot follows key_in, multi-hot gives 0
        key_in = 9'h004; push_exp(9'h004); step(); chk_note("idle_onehot");
        key_in = 9'h00C; push_exp(9'h000); step(); chk_note("idle_multihot");
        key_in = 9'h000; push_exp(9'h000); step(); chk_note("idle_zero");

        // play on an empty channel is ignored
        chan_sel = 1'b1; play_en = 1'b1; step();
        chk("empty_play", 32'(playing), 0);
        play_en = 1'b0; step();

        // record channel 0, multi-hot strobe between valid ones
        chan_sel = 1'b0; rec_en = 1'b1; push_exp(9'h000); step();
        chk_note("rec_entry_note");
        chk("rec_entry", 32'(recording), 1);
        chk("rec_entry_idx", 32'(step_idx), 0);
        for (int i = 0; i < 4; i++) begin
            key_in = rec_seq[i]; key_strobe = 1'b1; push_exp(rec_seq[i]); step();
            key_strobe = 1'b0;
            chk_note("rec_echo");
            chk("rec_idx", 32'(step_idx), 32'(rec_idx[i]));
            if (i == 1) begin
                key_in = 9'h101; key_strobe = 1'b1; push_exp(9'h000); step();
                key_strobe = 1'b0;
                chk_note("multihot_note");
                chk("multihot_idx", 32'(step_idx), 2);
                chk("multihot_full", 32'(full), 0);
            end
        end
        chk("full_after_4", 32'(full), 2'b01);
        key_in = 9'h002; key_strobe = 1'b1; push_exp(9'h000); step();
        key_strobe = 1'b0;
        chk_note("fifth_ignored");
        chk("fifth_full", 32'(full), 2'b01);
        rec_en = 1'b0; key_in = '0; step();
        chk("rec_exit", 32'(recording), 0);

        // rec_en and play_en together: record wins (channel 1, one step)
        chan_sel = 1'b1; rec_en = 1'b1; play_en = 1'b1; step();
        chk("both_rec", 32'(recording), 1);
        chk("both_play", 32'(playing), 0);
        play_en = 1'b0;
        key_in = 9'h010; key_strobe = 1'b1; step(); key_strobe = 1'b0;
        rec_en = 1'b0; key_in = '0; step();
        chk("ch1_full", 32'(full), 2'b01);

        // play channel 0 without loop
        chan_sel = 1'b0; play_en = 1'b1;
        for (int i = 0; i < 4; i++) for (int t = 0; t < TICK_DIV; t++) push_exp(rec_seq[i]);
        for (int c = 0; c < 4 * TICK_DIV; c++) begin
            step();
            chk_note("play_note");
            chk("play_idx", 32'(step_idx), 32'(c / TICK_DIV));
            chk("play_flag", 32'(playing), 1);
        end
        push_exp(9'h000); step(); chk_note("done_note");
        chk("done_play", 32'(playing), 0);
        push_exp(9'h000); step(); chk_note("done_hold");
        play_en = 1'b0; push_exp(9'h000); step(); chk_note("done_exit");

        // play channel 0 with loop requested
        loop = 1'b1; play_en = 1'b1;
        for (int i = 0; i < 4; i++) for (int t = 0; t < TICK_DIV; t++) push_exp(rec_seq[i]);
        for (int c = 0; c < 4 * TICK_DIV; c++) begin step(); chk_note("loop_note"); end
`ifdef SEQ_SAMPLER_LOOP_EN
        push_exp(9'h100); step(); chk_note("loop_wrap");
        chk("loop_play", 32'(playing), 1);
        chk("loop_idx", 32'(step_idx), 0);
`else
        push_exp(9'h000); step(); chk_note("loop_ignored");
        chk("loop_play", 32'(playing), 0);
`endif
        play_en = 1'b0; loop = 1'b0; push_exp(9'h000); step(); chk_note("loop_exit");
        chk("loop_exit_play", 32'(playing), 0);

        // channel 1 kept its own single step
        chan_sel = 1'b1; play_en = 1'b1;
        for (int t = 0; t < TICK_DIV; t++) push_exp(9'h010);
        push_exp(9'h000);
        for (int c = 0; c <= TICK_DIV; c++) begin step(); chk_note("ch1_note"); end
        play_en = 1'b0; step();

        // clear channel 1, then play on it is ignored
        clear = 1'b1; step(); clear = 1'b0;
        play_en = 1'b1; step();
        chk("cleared_play", 32'(playing), 0);
        play_en = 1'b0; step();
        chk("clear_keeps_ch0", 32'(full), 2'b01);

        // reset in the middle of playback on channel 0
        chan_sel = 1'b0; play_en = 1'b1;
        repeat (4) step();
        chk("pre_rst_play", 32'(playing), 1);
        reset = 1'b0; #1;
        chk("mid_rst_note", 32'(note_out), 0);
        chk("mid_rst_play", 32'(playing), 0);
        chk("mid_rst_full", 32'(full), 0);
        chk("mid_rst_idx",  32'(step_idx), 0);
        play_en = 1'b0;
        step();
        reset = 1'b1;
        play_en = 1'b1; push_exp(9'h000); step(); chk_note("post_rst_note");
        chk("post_rst_play", 32'(playing), 0);
        play_en = 1'b0; step();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_sampler.md
SEQ_SAMPLER -- requirements
Module: seq_sampler

Interface
REQ-001 SHALL have parameter KEYS, default 9: key/note vector width, one bit per key.
REQ-002 SHALL have parameter DEPTH, default 16: maximum steps stored per channel.
REQ-003 SHALL have parameter CHANNELS, default 4: number of independent sequence channels.
REQ-004 SHALL have parameter TICK_DIV, default 4: clock cycles per playback step, minimum 1.
REQ-005 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port key_in, input, KEYS: live key levels.
REQ-008 SHALL have port key_strobe, input, 1: one-cycle pulse that captures one record step.
REQ-009 SHALL have port chan_sel, input, clog2(CHANNELS), minimum 1: target channel, sampled only in IDLE.
REQ-010 SHALL have ports rec_en, play_en, loop and clear, each input, 1: record request, play request, loop playback and clear-channel pulse.
REQ-011 SHALL have port note_out, output, KEYS: registered note output.
REQ-012 SHALL have ports recording and playing, each output, 1: high in RECORD and PLAY respectively.
REQ-013 SHALL have ports full, output, CHANNELS (per-channel length==DEPTH), and step_idx, output, clog2(DEPTH): current record or play pointer.

Function
REQ-014 SHALL implement FSM states IDLE, RECORD, PLAY and DONE.
REQ-015 SHALL make note_out in IDLE equal the previous cycle's key_in if it is one-hot and 0 otherwise, with 1-cycle latency.
REQ-016 SHALL, in IDLE, go to RECORD on rec_en and latch chan_sel; if not recording, go to PLAY on play_en when the selected length is >0; rec_en SHALL win when both are high.
REQ-017 SHALL ignore play_en on a channel with length 0 and stay in IDLE.
REQ-018 SHALL, on clear in IDLE, set the selected channel's length to 0; clear SHALL be ignored in other states.
REQ-019 SHALL, in RECORD, restart the channel on entry (length=0) and, on each key_strobe with key_in one-hot or zero (zero = rest), write key_in at index length and then increment length.
REQ-020 SHALL ignore multi-hot strobes and all strobes once length==DEPTH; full SHALL assert the cycle after the DEPTH-th write.
REQ-021 SHALL set note_out to the captured key_in for one cycle after each accepted strobe in RECORD, and to 0 otherwise.
REQ-022 SHALL leave RECORD for IDLE when rec_en falls and keep the recorded data and length.
REQ-023 SHALL, in PLAY, start the tick counter at 0 on entry, output entry 0 on the first cycle of PLAY, and advance the pointer each time TICK_DIV cycles elapse.
REQ-024 SHALL, after the last entry (index length-1) has been held TICK_DIV cycles, go to DONE and drive note_out=0, or wrap to index 0 when loop is high (see REQ-029).
REQ-025 SHALL go from PLAY or DONE to IDLE when play_en falls, with note_out=0 in that cycle.
REQ-026 SHALL keep the other channels' contents untouched by any operation on one channel.

Reset
REQ-027 SHALL, on asserted reset, immediately set state=IDLE, all lengths=0, note_out=0, recording=0, playing=0, full=0, step_idx=0 and clear the tick counter; storage array contents need not be reset.
REQ-028 SHALL, on reset mid-RECORD or mid-PLAY, abandon the operation and leave every channel empty.

Configuration
REQ-029 SHALL compile looping in with SEQ_SAMPLER_LOOP_EN defined, honouring loop per REQ-024; without the macro, loop SHALL be ignored and playback always ends in DONE.

Structure
REQ-030 SHALL place the FSM state encoding and the default parameter constants in shared package seq_sampler_pkg.
REQ-031 SHALL implement the playback step enable in sub-module seq_tick_gen: a TICK_DIV counter, cleared on PLAY entry, that pulses one cycle per period.

Verification
REQ-032 SHALL cover recording with KEYS=9, DEPTH=4, CHANNELS=2, TICK_DIV=3, chan 0, strobes 0x100,0x080,0x000,0x001 -> length=4, full[0]=1, and a fifth strobe ignored.
REQ-033 SHALL cover playback of that chan 0 with loop=0 -> note_out 0x100,0x080,0x000,0x001 each for 3 cycles, then DONE with note_out=0.
REQ-034 SHALL cover a multi-hot strobe 0x101 in RECORD -> no write, length unchanged, note_out=0.
REQ-035 SHALL cover rec_en and play_en asserted together in IDLE -> RECORD entered, recording=1, playing=0.
REQ-036 SHALL cover looped playback with SEQ_SAMPLER_LOOP_EN defined, loop=1 -> after 0x001 the output wraps to 0x100; without the macro it ends in DONE.
REQ-037 SHALL cover reset asserted mid-PLAY on chan 0 -> outputs 0 immediately, full=0, and a following play_en on chan 0 is ignored.
